// File: rtl/vex_bus_responder.sv
// Bridges the VexRiscv simple iBus/dBus ports onto one shared single-port SoC memory bus.
// dBus has priority, reads take one response cycle, and the debug unit preempts when busy.
module vex_bus_responder #(
  parameter logic [31:0] MAP_MASK  = 32'hFFFC_0000,
  parameter logic [31:0] HOLE_BASE = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_cmd_valid,
  output logic        ibus_cmd_ready,
  input  logic [31:0] ibus_cmd_pc,
  output logic        ibus_rsp_valid,
  output logic        ibus_rsp_error,
  output logic [31:0] ibus_rsp_inst,
  input  logic        dbus_cmd_valid,
  output logic        dbus_cmd_ready,
  input  logic        dbus_cmd_wr,
  input  logic [3:0]  dbus_cmd_mask,
  input  logic [31:0] dbus_cmd_address,
  input  logic [31:0] dbus_cmd_data,
  input  logic [1:0]  dbus_cmd_size,
  output logic        dbus_rsp_ready,
  output logic        dbus_rsp_error,
  output logic [31:0] dbus_rsp_data,
  input  logic        ext_busy,
  output logic        mem_op,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_di,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_do,
  output logic        bus_fault
);

  typedef enum logic [2:0] {
    IDLE,
    IRSP,
    DRSP,
    ERSP_I,
    ERSP_D
  } state_t;

  state_t state;
  state_t state_next;
  logic   fault_next;
  logic   slot_free;
  logic   d_mapped;
  logic   i_mapped;
  logic   size_unused;

  // Access size is informational only; the byte mask decides what is written.
  assign size_unused = ^dbus_cmd_size;

  function automatic logic is_mapped(input logic [31:0] adr);
    return ((adr & MAP_MASK) == '0) && (adr[17:16] != HOLE_BASE[17:16]);
  endfunction

  assign d_mapped = is_mapped(dbus_cmd_address);
  assign i_mapped = is_mapped(ibus_cmd_pc);

  // Command side is combinational so the RAM sees its select in the accept cycle;
  // gating with reset keeps every output low while reset is held.
  assign slot_free = (state == IDLE) && !ext_busy && !reset;

  always_comb begin
    ibus_cmd_ready = 1'b0;
    dbus_cmd_ready = 1'b0;
    ibus_rsp_valid = 1'b0;
    ibus_rsp_error = 1'b0;
    ibus_rsp_inst  = '0;
    dbus_rsp_ready = 1'b0;
    dbus_rsp_error = 1'b0;
    dbus_rsp_data  = '0;
    mem_op         = 1'b0;
    mem_adr        = '0;
    mem_di         = '0;
    mem_wren       = '0;
    fault_next     = 1'b0;
    state_next     = IDLE;

    if (slot_free && dbus_cmd_valid) begin
      dbus_cmd_ready = 1'b1;
      if (d_mapped) begin
        mem_op  = 1'b1;
        mem_adr = dbus_cmd_address;
        if (dbus_cmd_wr) begin
          mem_wren = dbus_cmd_mask;
          mem_di   = dbus_cmd_data;
        end
      end
      if (dbus_cmd_wr) begin
        fault_next = !d_mapped;
        state_next = IDLE;
      end else begin
        state_next = d_mapped ? DRSP : ERSP_D;
      end
    end else if (slot_free && ibus_cmd_valid) begin
      ibus_cmd_ready = 1'b1;
      if (i_mapped) begin
        mem_op  = 1'b1;
        mem_adr = ibus_cmd_pc;
      end
      state_next = i_mapped ? IRSP : ERSP_I;
    end

    case (state)
      IRSP: begin
        ibus_rsp_valid = 1'b1;
        ibus_rsp_inst  = mem_do;
      end
      DRSP: begin
        dbus_rsp_ready = 1'b1;
        dbus_rsp_data  = mem_do;
      end
      ERSP_I: begin
        ibus_rsp_valid = 1'b1;
        ibus_rsp_error = 1'b1;
      end
      ERSP_D: begin
        dbus_rsp_ready = 1'b1;
        dbus_rsp_error = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bus_fault <= 1'b0;
    end else begin
      state     <= state_next;
      bus_fault <= fault_next;
    end
  end

endmodule

// File: tb/tb_vex_bus_responder.sv
// Randomised scoreboard bench for vex_bus_responder: a reference model predicts acceptance and
// responses, and a separate monitor pops expected responses as the DUT presents them.
module tb_vex_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_cmd_valid, ibus_cmd_ready;
  logic [31:0] ibus_cmd_pc;
  logic        ibus_rsp_valid, ibus_rsp_error;
  logic [31:0] ibus_rsp_inst;
  logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_wr;
  logic [3:0]  dbus_cmd_mask;
  logic [31:0] dbus_cmd_address, dbus_cmd_data;
  logic [1:0]  dbus_cmd_size;
  logic        dbus_rsp_ready, dbus_rsp_error;
  logic [31:0] dbus_rsp_data;
  logic        ext_busy;
  logic        mem_op;
  logic [31:0] mem_adr, mem_di;
  logic [3:0]  mem_wren;
  logic [31:0] mem_do = '0;
  logic        bus_fault;

  vex_bus_responder #(.MAP_MASK(32'hFFFC_0000), .HOLE_BASE(32'h0003_0000)) dut (
    .clk(clk), .reset(reset),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready), .ibus_cmd_pc(ibus_cmd_pc),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_error(ibus_rsp_error), .ibus_rsp_inst(ibus_rsp_inst),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready), .dbus_cmd_wr(dbus_cmd_wr),
    .dbus_cmd_mask(dbus_cmd_mask), .dbus_cmd_address(dbus_cmd_address),
    .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_size(dbus_cmd_size),
    .dbus_rsp_ready(dbus_rsp_ready), .dbus_rsp_error(dbus_rsp_error), .dbus_rsp_data(dbus_rsp_data),
    .ext_busy(ext_busy), .mem_op(mem_op), .mem_adr(mem_adr), .mem_di(mem_di),
    .mem_wren(mem_wren), .mem_do(mem_do), .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  // SoC RAM environment: 256K bytes, synchronous read one cycle after select.
  logic [31:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_op) begin
      for (int b = 0; b < 4; b++)
        if (mem_wren[b]) ram[mem_adr[17:2]][8*b +: 8] <= mem_di[8*b +: 8];
      mem_do <= ram[mem_adr[17:2]];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the mapped window is simply [0, 0x3_0000).
  logic [31:0] ref_mem [0:65535];
  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] data;
  } rsp_t;
  rsp_t iq[$];
  rsp_t dq[$];
  logic slot_busy = 1'b0;
  logic fault_exp = 1'b0;
  logic i_acc, d_acc;

  function automatic logic ref_mapped(input logic [31:0] adr);
    return adr < 32'h0003_0000;
  endfunction

  // Current CPU requests (held until accepted) and debug-unit activity.
  logic        iv = 1'b0, dv = 1'b0, dwr = 1'b0, busy = 1'b0;
  logic [31:0] ipc = '0, dadr = '0, ddata = '0;
  logic [3:0]  dmask = '0;

  task automatic cycle();
    logic        exp_op;
    logic [31:0] exp_adr;
    logic [3:0]  exp_wren;
    logic        m;
    rsp_t        r;
    @(negedge clk);
    ibus_cmd_valid = iv; ibus_cmd_pc = ipc;
    dbus_cmd_valid = dv; dbus_cmd_wr = dwr; dbus_cmd_mask = dmask;
    dbus_cmd_address = dadr; dbus_cmd_data = ddata; dbus_cmd_size = 2'd2;
    ext_busy = busy;
    #2;
    chk("bus_fault", {31'd0, bus_fault}, {31'd0, fault_exp});
    d_acc = dv && !busy && !slot_busy;
    i_acc = iv && !busy && !slot_busy && !dv;
    chk("dbus_cmd_ready", {31'd0, dbus_cmd_ready}, {31'd0, d_acc});
    chk("ibus_cmd_ready", {31'd0, ibus_cmd_ready}, {31'd0, i_acc});
    exp_op = 1'b0; exp_adr = '0; exp_wren = '0;
    fault_exp = 1'b0; slot_busy = 1'b0;
    if (d_acc) begin
      m = ref_mapped(dadr);
      if (m) begin
        exp_op = 1'b1; exp_adr = dadr; exp_wren = dwr ? dmask : 4'd0;
      end
      if (dwr) begin
        if (m) begin
          for (int b = 0; b < 4; b++)
            if (dmask[b]) ref_mem[dadr[17:2]][8*b +: 8] = ddata[8*b +: 8];
        end else begin
          fault_exp = 1'b1;
        end
      end else begin
        r.due = cyc + 1; r.err = !m; r.data = m ? ref_mem[dadr[17:2]] : 32'd0;
        dq.push_back(r);
        slot_busy = 1'b1;
      end
    end else if (i_acc) begin
      m = ref_mapped(ipc);
      if (m) begin
        exp_op = 1'b1; exp_adr = ipc;
      end
      r.due = cyc + 1; r.err = !m; r.data = m ? ref_mem[ipc[17:2]] : 32'd0;
      iq.push_back(r);
      slot_busy = 1'b1;
    end
    chk("mem_op", {31'd0, mem_op}, {31'd0, exp_op});
    chk("mem_adr", mem_adr, exp_adr);
    chk("mem_wren", {28'd0, mem_wren}, {28'd0, exp_wren});
    if (!exp_op) chk("mem_di_idle", mem_di, 32'd0);
    else if (d_acc && dwr) chk("mem_di", mem_di, ddata);
  endtask

  task automatic step();
    cycle();
    if (i_acc) iv = 1'b0;
    if (d_acc) dv = 1'b0;
  endtask

  // Response monitor, decoupled from stimulus.
  always @(negedge clk) begin : monitor
    rsp_t r;
    #3;
    if (iq.size() > 0 && iq[0].due == cyc) begin
      r = iq.pop_front();
      chk("ibus_rsp_valid", {31'd0, ibus_rsp_valid}, 32'd1);
      chk("ibus_rsp_error", {31'd0, ibus_rsp_error}, {31'd0, r.err});
      chk("ibus_rsp_inst", ibus_rsp_inst, r.data);
    end else begin
      chk("ibus_rsp_quiet", {ibus_rsp_valid, ibus_rsp_error, 30'd0}, 32'd0);
      chk("ibus_rsp_inst_quiet", ibus_rsp_inst, 32'd0);
    end
    if (dq.size() > 0 && dq[0].due == cyc) begin
      r = dq.pop_front();
      chk("dbus_rsp_ready", {31'd0, dbus_rsp_ready}, 32'd1);
      chk("dbus_rsp_error", {31'd0, dbus_rsp_error}, {31'd0, r.err});
      chk("dbus_rsp_data", dbus_rsp_data, r.data);
    end else begin
      chk("dbus_rsp_quiet", {dbus_rsp_ready, dbus_rsp_error, 30'd0}, 32'd0);
      chk("dbus_rsp_data_quiet", dbus_rsp_data, 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ibus_cmd_ready"}, {31'd0, ibus_cmd_ready}, 32'd0);
    chk({tag, "_dbus_cmd_ready"}, {31'd0, dbus_cmd_ready}, 32'd0);
    chk({tag, "_ibus_rsp"}, {ibus_rsp_valid, ibus_rsp_error, 30'd0}, 32'd0);
    chk({tag, "_ibus_rsp_inst"}, ibus_rsp_inst, 32'd0);
    chk({tag, "_dbus_rsp"}, {dbus_rsp_ready, dbus_rsp_error, 30'd0}, 32'd0);
    chk({tag, "_dbus_rsp_data"}, dbus_rsp_data, 32'd0);
    chk({tag, "_mem_op"}, {31'd0, mem_op}, 32'd0);
    chk({tag, "_mem_adr"}, mem_adr, 32'd0);
    chk({tag, "_mem_di"}, mem_di, 32'd0);
    chk({tag, "_mem_wren"}, {28'd0, mem_wren}, 32'd0);
    chk({tag, "_bus_fault"}, {31'd0, bus_fault}, 32'd0);
  endtask

  function automatic logic [31:0] rand_adr();
    case ($urandom_range(0, 7))
      0, 1, 2: return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      3:       return 32'h0001_0000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      4:       return 32'h0003_0000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      5:       return ($urandom_range(0, 1) == 0) ? 32'h0002_FFFC : 32'h0004_0000;
      default: return $urandom() | 32'h0010_0000;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = $urandom();
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'h0000_0013;
    ref_mem[4] = 32'h0000_0013;

    reset = 1'b1;
    ibus_cmd_valid = 1'b0; ibus_cmd_pc = '0;
    dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0; dbus_cmd_mask = '0;
    dbus_cmd_address = '0; dbus_cmd_data = '0; dbus_cmd_size = '0;
    ext_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    reset = 1'b0;

    // Fetch of RAM[4], then a byte store.
    iv = 1'b1; ipc = 32'h0000_0010;
    repeat (2) step();
    dv = 1'b1; dwr = 1'b1; dadr = 32'h0001_0000; ddata = 32'h0000_00AB; dmask = 4'b0001;
    repeat (2) step();

    // Simultaneous fetch and load: dBus first, iBus in the next free slot.
    iv = 1'b1; ipc = 32'h0000_0200;
    dv = 1'b1; dwr = 1'b0; dadr = 32'h0000_0100;
    repeat (5) step();

    // Load then store into the unmapped hole.
    dv = 1'b1; dwr = 1'b0; dadr = 32'h0003_0000;
    repeat (2) step();
    dv = 1'b1; dwr = 1'b1; dadr = 32'h0003_0000; ddata = 32'h1234_5678; dmask = 4'hF;
    repeat (3) step();

    // Debug unit owns the bus for five cycles while a fetch waits.
    iv = 1'b1; ipc = 32'h0000_0010; busy = 1'b1;
    repeat (5) step();
    busy = 1'b0;
    repeat (3) step();

    // Reset lands in the accept cycle of a fetch: no response may follow.
    @(negedge clk);
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h0000_0010;
    dbus_cmd_valid = 1'b0; ext_busy = 1'b0;
    #1 chk("pre_reset_ibus_ready", {31'd0, ibus_cmd_ready}, 32'd1);
    #1 reset = 1'b1;
    iq.delete(); dq.delete(); slot_busy = 1'b0; fault_exp = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0; ibus_cmd_valid = 1'b0; iv = 1'b0; dv = 1'b0;
    repeat (2) step();

    // Randomised traffic with random debug-unit preemption.
    for (int n = 0; n < 4000; n++) begin
      if (!iv && $urandom_range(0, 2) == 0) begin
        iv = 1'b1; ipc = rand_adr();
      end
      if (!dv && $urandom_range(0, 2) == 0) begin
        dv = 1'b1; dwr = 1'($urandom_range(0, 1)); dadr = rand_adr();
        ddata = $urandom(); dmask = 4'($urandom_range(0, 15));
      end
      busy = ($urandom_range(0, 4) == 0);
      step();
    end

    iv = 1'b0; dv = 1'b0; busy = 1'b0;
    repeat (3) step();
    chk("queues_drained", iq.size() + dq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
